// File: rtl/lzx_cmp_pkg.sv
// Shared types and the cascade-resolution rule for the sequential magnitude comparator.
// The cascade rule mirrors the 74HC85 behaviour when every slice compares equal.
package lzx_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } state_t;

  typedef struct packed {
    logic g;
    logic e;
    logic l;
  } res_t;

  // An asserted equal input wins; otherwise g/l pass through, both set gives 000, neither gives 101.
  function automatic res_t cascade_resolve(input logic g, input logic e, input logic l);
    res_t r;
    r = '0;
    if (e) begin
      r.e = 1'b1;
    end else begin
      case ({g, l})
        2'b10:   r.g = 1'b1;
        2'b01:   r.l = 1'b1;
        2'b11:   r = '0;
        default: begin
          r.g = 1'b1;
          r.l = 1'b1;
        end
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/lzx_cmp_slice.sv
// Combinational compare of one slice of the two operands.
// When msb_inv is set, the top bit is flipped so that two's-complement order becomes unsigned order.
module lzx_cmp_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_s,
  input  logic [SLICE-1:0] b_s,
  input  logic             msb_inv,
  output logic             gt,
  output logic             lt
);

  logic [SLICE-1:0] flip;
  logic [SLICE-1:0] a_m;
  logic [SLICE-1:0] b_m;

  always_comb begin
    flip            = '0;
    flip[SLICE-1]   = msb_inv;
  end

  assign a_m = a_s ^ flip;
  assign b_m = b_s ^ flip;
  assign gt  = a_m > b_m;
  assign lt  = a_m < b_m;

endmodule

// File: rtl/lzx_seq_mag_cmp.sv
// Sequential magnitude comparator: one slice per clock, starting at the MSB slice, with an early exit.
// If every slice is equal, the cascade inputs decide the result.
//
//   state | meaning
//   IDLE  | ready for a new operand set; the last result stays on the outputs
//   CMP   | comparing slice idx; leaves on the first difference or after slice 0
//   DONE  | result presented with out_valid until out_ready
module lzx_seq_mag_cmp
  import lzx_cmp_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int SLICE  = 4,
  parameter int SIGNED = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WIDTH-1:0]                    a,
  input  logic [WIDTH-1:0]                    b,
  input  logic                                ia_g,
  input  logic                                ia_e,
  input  logic                                ia_l,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                qa_g,
  output logic                                qa_e,
  output logic                                qa_l,
  output logic [$clog2(WIDTH/SLICE+1)-1:0]    cycles
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = $clog2(NSLICE + 1);
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  res_t             casc_q;
  logic [IW-1:0]    idx_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cycles_q;
  res_t             res_q, res_d;
  logic             load, finish;
  logic             msb_inv, gt, lt;
  logic [SLICE-1:0] a_s, b_s;

  assign a_s     = a_q[int'(idx_q)*SLICE +: SLICE];
  assign b_s     = b_q[int'(idx_q)*SLICE +: SLICE];
  assign msb_inv = (SIGNED != 0) && (idx_q == IW'(NSLICE - 1));

  lzx_cmp_slice #(.SLICE(SLICE)) u_slice (
    .a_s     (a_s),
    .b_s     (b_s),
    .msb_inv (msb_inv),
    .gt      (gt),
    .lt      (lt)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    finish  = 1'b0;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = CMP;
        end
      end
      CMP: begin
        if (gt || lt) begin
          finish  = 1'b1;
          res_d   = '{g: gt, e: 1'b0, l: lt};
          state_d = DONE;
        end else if (idx_q == '0) begin
          finish  = 1'b1;
          res_d   = cascade_resolve(casc_q.g, casc_q.e, casc_q.l);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      casc_q   <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      cycles_q <= '0;
      res_q    <= '0;
    end else if (load) begin
      a_q    <= a;
      b_q    <= b;
      casc_q <= '{g: ia_g, e: ia_e, l: ia_l};
      idx_q  <= IW'(NSLICE - 1);
      cnt_q  <= '0;
    end else if (state_q == CMP) begin
      cnt_q <= cnt_q + CW'(1);
      if (finish) begin
        res_q    <= res_d;
        cycles_q <= cnt_q + CW'(1);
      end else begin
        idx_q <= idx_q - IW'(1);
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign qa_g      = res_q.g;
  assign qa_e      = res_q.e;
  assign qa_l      = res_q.l;
  assign cycles    = cycles_q;

endmodule
